mem_access_sequencer: RTL and testbench

//  Sequences the single shared synchronous memory port between instruction fetch and lw/sw data access
//  in the single-cycle MIPS core. Holds the fetched instruction, issues data accesses, drives pc_stall.

---
 rtl/mem_seq_pkg.sv | 19 +
 rtl/mem_lat_timer.sv | 30 +++
 rtl/mem_access_sequencer.sv | 148 ++++++++++++++
 tb/tb_mem_access_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and limits for the memory access sequencer.
// Holds the state encoding, the legal MEM_LAT range, the stall counter width and a saturating increment helper.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        D_WAIT  = 2'd2
    } seq_state_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;
    localparam int STALL_CNT_W = 16;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter that flags the cycle in which the read data is due (MEM_LAT cycles after the load).
// Latency: o_expire is high in cycle load+MEM_LAT; there is no backpressure, and a new load restarts the count.
module mem_lat_timer
#(
    parameter int MEM_LAT = 1
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_expire
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= LOAD_VAL;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_access_sequencer.sv
// Sole master of the shared memory port: fetch and load take MEM_LAT+1 cycles, a store takes 1.
// The PC is held with pc_stall while an access is pending; define SEQ_PERF_CNT_EN to enable the stall_cnt counter.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [ADDR_W-1:0]      if_addr,
    output logic                   if_valid,
    output logic [DATA_W-1:0]      if_rdata,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [ADDR_W-1:0]      d_addr,
    input  logic [DATA_W-1:0]      d_wdata,
    output logic                   d_done,
    output logic [DATA_W-1:0]      d_rdata,
    output logic                   pc_stall,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
        $error("mem_access_sequencer: MEM_LAT out of range 1..4");
    end

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic              r_if_valid;
    logic              r_d_done;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_fetch_go;
    logic              w_data_go;
    logic              w_expire;
    logic              w_pc_stall;
    logic              w_if_cap;
    logic              w_d_cap;

    // Fetch needs an empty instruction register and data needs a full one, so the two never collide.
    assign w_fetch_go = (r_state == IDLE) && !r_if_valid && if_req;
    assign w_data_go  = (r_state == IDLE) && r_if_valid && d_req && !r_d_done;
    assign w_pc_stall = ~(r_if_valid & (~d_req | r_d_done));
    assign w_if_cap   = (r_state == IF_WAIT) && w_expire;
    assign w_d_cap    = (r_state == D_WAIT) && w_expire;

    mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_fetch_go | (w_data_go & ~d_we)),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_fetch_go)
                    w_next = IF_WAIT;
                else if (w_data_go && !d_we)
                    w_next = D_WAIT;
            end
            IF_WAIT, D_WAIT: begin
                if (w_expire)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_fetch_go) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (w_data_go) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_rdata <= '0;
        end else if (w_if_cap) begin
            r_if_valid <= 1'b1;
            r_if_rdata <= mem_rdata;
        end else if (!w_pc_stall) begin
            r_if_valid <= 1'b0;
        end
    end

    // Stores complete on the issue edge; loads complete on the capture edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_done  <= 1'b0;
            r_d_rdata <= '0;
        end else begin
            r_d_done <= (w_data_go & d_we) | w_d_cap;
            if (w_d_cap)
                r_d_rdata <= mem_rdata;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_pc_stall)
            r_stall_cnt <= sat_inc(r_stall_cnt);
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

    assign if_valid = r_if_valid;
    assign if_rdata = r_if_rdata;
    assign d_done   = r_d_done;
    assign d_rdata  = r_d_rdata;
    assign pc_stall = w_pc_stall;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: a MEM_LAT=1 instance under random fetch/lw/sw traffic and a MEM_LAT=4 instance for fetch timing.
module tb_mem_access_sequencer;

    localparam int LAT  = 1;
    localparam int LAT4 = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        pc_stall;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] stall_cnt;

    logic        l4_if_req = 1'b0;
    logic [7:0]  l4_if_addr = '0;
    logic        l4_if_valid;
    logic [31:0] l4_if_rdata;
    logic        l4_d_done;
    logic [31:0] l4_d_rdata;
    logic        l4_pc_stall;
    logic        l4_mem_en;
    logic        l4_mem_we;
    logic [7:0]  l4_mem_addr;
    logic [31:0] l4_mem_wdata;
    logic [31:0] l4_mem_rdata;
    logic [15:0] l4_stall_cnt;

    mem_access_sequencer #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .pc_stall(pc_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    mem_access_sequencer #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT4)) dut_l4 (
        .clk(clk), .rst(rst),
        .if_req(l4_if_req), .if_addr(l4_if_addr), .if_valid(l4_if_valid), .if_rdata(l4_if_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(32'h0),
        .d_done(l4_d_done), .d_rdata(l4_d_rdata), .pc_stall(l4_pc_stall),
        .mem_en(l4_mem_en), .mem_we(l4_mem_we), .mem_addr(l4_mem_addr), .mem_wdata(l4_mem_wdata),
        .mem_rdata(l4_mem_rdata), .stall_cnt(l4_stall_cnt)
    );

    // Environment memory; ref_mem is the bench's own idea of what it should hold.
    logic [31:0] ram [256];
    logic [31:0] ref_mem [256];
    logic        ld_we = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [31:0] ld_dat = '0;
    logic [31:0] l4_q [4];

    always @(posedge clk) begin
        if (ld_we)
            ram[ld_addr] <= ld_dat;
        else if (mem_en && mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_en && !mem_we) ? ram[mem_addr] : 32'hBADC0DE1;
        l4_q[0]   <= (l4_mem_en && !l4_mem_we) ? ram[l4_mem_addr] : 32'hBADC0DE4;
        for (int i = 1; i < 4; i++)
            l4_q[i] <= l4_q[i-1];
    end
    assign l4_mem_rdata = l4_q[3];

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    int          n_chk = 0;
    int          n_fail = 0;
    int          retired = 0;
    logic [31:0] last_ld = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Every retired instruction owns exactly one non-stalled cycle; all other cycles stall.
    function automatic logic [63:0] exp_stall();
`ifdef SEQ_PERF_CNT_EN
        int s;
        s = cyc - retired;
        return (s > 65535) ? 64'd65535 : 64'(s);
`else
        return 64'd0;
`endif
    endfunction

    task automatic fetch(input logic [7:0] a);
        int n;
        @(negedge clk);
        d_req   = 1'b0;
        if_req  = 1'b1;
        if_addr = a;
        #1;
        chk("stall_cnt", 64'(stall_cnt), exp_stall());
        chk("if_clear", 64'(if_valid), 64'd0);
        chk("fetch_cmd", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b0, a}));
        chk("fetch_stall", 64'(pc_stall), 64'd1);
        n = 0;
        while (!if_valid && n < 20) begin
            @(negedge clk);
            if_req = 1'b0;
            #1;
            n++;
        end
        chk("fetch_lat", 64'(n), 64'(LAT + 1));
        chk("if_rdata", 64'(if_rdata), 64'(ref_mem[a]));
    endtask

    task automatic do_nop();
        chk("nop_release", 64'(pc_stall), 64'd0);
        retired++;
    endtask

    task automatic do_load(input logic [7:0] a);
        int n;
        d_req = 1'b1; d_we = 1'b0; d_addr = a;
        #1;
        chk("ld_cmd", 64'({mem_en, mem_we, mem_addr}), 64'({1'b1, 1'b0, a}));
        chk("ld_stall", 64'(pc_stall), 64'd1);
        n = 0;
        while (!d_done && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ld_lat", 64'(n), 64'(LAT + 1));
        chk("d_rdata", 64'(d_rdata), 64'(ref_mem[a]));
        chk("ld_release", 64'(pc_stall), 64'd0);
        last_ld = ref_mem[a];
        retired++;
    endtask

    task automatic do_store(input logic [7:0] a, input logic [31:0] v);
        int n;
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
        #1;
        chk("st_cmd", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'({1'b1, 1'b1, a, v}));
        ref_mem[a] = v;
        n = 0;
        while (!d_done && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("st_lat", 64'(n), 64'd1);
        chk("st_release", 64'(pc_stall), 64'd0);
        chk("d_rdata_hold", 64'(d_rdata), 64'(last_ld));
        retired++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          op;
        logic [7:0]  a;
        logic [31:0] v;

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            v = $urandom;
            if (i == 8'h04) v = 32'h8C010000;
            if (i == 8'h40) v = 32'hDEADBEEF;
            ld_we = 1'b1; ld_addr = 8'(i); ld_dat = v;
            ref_mem[i] = v;
        end
        @(negedge clk);
        ld_we = 1'b0;
        #1;
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_d_done", 64'(d_done), 64'd0);
        chk("rst_mem_en", 64'({mem_en, mem_we}), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_pc_stall", 64'(pc_stall), 64'd1);
        rst = 1'b0;

        fetch(8'h04); do_nop();
        fetch(8'h08); do_load(8'h40);
        fetch(8'h0C); do_store(8'h44, 32'h12345678);
        fetch(8'h10); do_load(8'h44);

        repeat (60) begin
            a = 8'($urandom_range(0, 63)) << 2;
            fetch(a);
            op = $urandom_range(0, 2);
            a = 8'($urandom_range(0, 15)) << 2;
            if (op == 0)
                do_nop();
            else if (op == 1)
                do_load(a);
            else
                do_store(a, $urandom);
        end

        // Reset in the middle of a load: the response must be dropped.
        fetch(8'h20);
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
        @(negedge clk);
        #1;
        rst = 1'b1;
        retired = 0;
        last_ld = '0;
        #1;
        chk("midrst_if_valid", 64'(if_valid), 64'd0);
        chk("midrst_d_done", 64'(d_done), 64'd0);
        chk("midrst_d_rdata", 64'(d_rdata), 64'd0);
        chk("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        d_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("midrst_no_done", 64'(d_done), 64'd0);
        end
        fetch(8'h24); do_load(8'h40);
        fetch(8'h28); do_nop();

        @(negedge clk);
        l4_if_req = 1'b1; l4_if_addr = 8'h04;
        #1;
        chk("l4_cmd", 64'({l4_mem_en, l4_mem_we, l4_mem_addr}), 64'({1'b1, 1'b0, 8'h04}));
        n = 0;
        while (!l4_if_valid && n < 20) begin
            @(negedge clk);
            l4_if_req = 1'b0;
            #1;
            n++;
            if (!l4_if_valid)
                chk("l4_en_quiet", 64'(l4_mem_en), 64'd0);
        end
        chk("l4_lat", 64'(n), 64'(LAT4 + 1));
        chk("l4_if_rdata", 64'(l4_if_rdata), 64'(ref_mem[8'h04]));
        chk("l4_release", 64'(l4_pc_stall), 64'd0);
        @(negedge clk);
        #1;
        chk("l4_clear", 64'(l4_if_valid), 64'd0);
        chk("stall_cnt_end", 64'(stall_cnt), exp_stall());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
